// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared stage-bus types and buffer state encoding
package CPU_buffer_bus;

  // Buffer occupancy states; the encoding doubles as the occ output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_buf_state_e;

  // Example stage bus: each stage sizes its buffer with $bits of its bus struct.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_bus_t;

  localparam int IF_ID_BUS_W = $bits(if_id_bus_t);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [7:0]  alu_op;
  } id_ex_bus_t;

  localparam int ID_EX_BUS_W = $bits(id_ex_bus_t);

  // Trace ports keep at least one bit so they can be declared when tracing is off.
  function automatic int trace_port_w(input int trace_w);
    return (trace_w > 0) ? trace_w : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - valid/ready stage-to-stage bus with upstream and downstream halves
interface pipe_stage_buf_if #(
  parameter int DATA_W  = 64,
  parameter int TRACE_W = 0
);
  import CPU_buffer_bus::*;

  localparam int TRACE_PW = trace_port_w(TRACE_W);

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [TRACE_PW-1:0] in_trace;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [TRACE_PW-1:0] out_trace;

  // Stage-side view: drives the beat in and consumes the beat out.
  modport master (
    output in_valid, in_data, in_trace, out_ready,
    input  in_ready, out_valid, out_data, out_trace
  );

  // Buffer-side view.
  modport slave (
    input  in_valid, in_data, in_trace, out_ready,
    output in_ready, out_valid, out_data, out_trace
  );

endinterface

// File: rtl/pipe_stage_buf_entry.sv
// rtl/pipe_stage_buf_entry.sv - single enable/clear register holding one packed beat
module pipe_buf_entry #(
  parameter int WIDTH = 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a flush never lets a beat slip through.
  always_ff @(posedge ACLK) begin
    if (ARESET || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid pipeline-stage buffer with stall and flush
module pipe_stage_buf
  import CPU_buffer_bus::*;
#(
  parameter int DATA_W      = 64,
  parameter int TRACE_W     = 0,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            stall_en,
  input  logic            flush_en,
  pipe_stage_buf_if.slave bus,
  output logic [1:0]      occ
);

  localparam int ENTRY_W = DATA_W + TRACE_W;

  pipe_buf_state_e state_q;
  pipe_buf_state_e state_d;
  logic            in_ready_q;
  logic            out_valid;
  logic            push;
  logic            pop;

  logic            main_en;
  logic            main_clr;
  logic            main_from_skid;
  logic            skid_en;
  logic            skid_clr;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_d;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;

  assign out_valid = (state_q != EMPTY);
  assign push      = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready & ~stall_en;

  // State and registered in_ready; in_ready looks at the next state so the
  // skid absorbs the beat already in flight when downstream stops.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Next-state: flush empties the buffer regardless of push/pop.
  always_comb begin
    state_d = state_q;
    if (flush_en) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) state_d = HALF;
        end
        HALF: begin
          if (push && !pop) begin
            state_d = FULL;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) state_d = HALF;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry controls: which register loads, from where, and which gets cleared.
  always_comb begin
    main_en        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    skid_clr       = 1'b0;
    if (flush_en) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          main_en = push;
        end
        HALF: begin
          if (push && pop) begin
            main_en = 1'b1;
          end else if (push) begin
            skid_en = 1'b1;
          end else if (pop && BUBBLE_ZERO) begin
            main_clr = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Data and trace are packed into one entry so they always move together.
  generate
    if (TRACE_W > 0) begin : g_trace
      assign in_entry      = {bus.in_trace, bus.in_data};
      assign bus.out_trace = main_q[ENTRY_W-1:DATA_W];
    end else begin : g_no_trace
      logic unused_trace;
      assign unused_trace  = ^bus.in_trace;
      assign in_entry      = bus.in_data;
      assign bus.out_trace = '0;
    end
  endgenerate

  assign main_d = main_from_skid ? skid_q : in_entry;

  pipe_buf_entry #(.WIDTH(ENTRY_W)) u_main (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .en     (main_en),
    .clr    (main_clr),
    .d      (main_d),
    .q      (main_q)
  );

  pipe_buf_entry #(.WIDTH(ENTRY_W)) u_skid (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .en     (skid_en),
    .clr    (skid_clr),
    .d      (in_entry),
    .q      (skid_q)
  );

  assign bus.out_data  = main_q[DATA_W-1:0];
  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready_q;
  assign occ           = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf against a queue model
module tb_pipe_stage_buf;
  import CPU_buffer_bus::*;

  localparam int DW = 16;
  localparam int TW = 8;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic stall_en = 1'b0;
  logic flush_en = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [TW-1:0] in_trace = '0;
  logic [1:0] occ_a;
  logic [1:0] occ_b;

  always #5 ACLK = ~ACLK;

  pipe_stage_buf_if #(.DATA_W(DW), .TRACE_W(0))  bus_a ();
  pipe_stage_buf_if #(.DATA_W(DW), .TRACE_W(TW)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_trace  = in_trace[0];
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_trace  = in_trace;
  assign bus_b.out_ready = out_ready;

  pipe_stage_buf #(.DATA_W(DW), .TRACE_W(0), .BUBBLE_ZERO(1'b1)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET), .stall_en(stall_en), .flush_en(flush_en),
    .bus(bus_a), .occ(occ_a)
  );

  pipe_stage_buf #(.DATA_W(DW), .TRACE_W(TW), .BUBBLE_ZERO(1'b0)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET), .stall_en(stall_en), .flush_en(flush_en),
    .bus(bus_b), .occ(occ_b)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } beat_t;

  beat_t q[$];
  beat_t hold_b = '0;
  bit m_in_ready = 1'b1;
  bit last_push = 1'b0;
  logic [DW-1:0] obs_a[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [31:0] ed_a, ed_b, et_b;
    n = q.size();
    if (n != 0) begin
      ed_a = 32'(q[0].d);
      ed_b = 32'(q[0].d);
      et_b = 32'(q[0].t);
    end else begin
      ed_a = 0;
      ed_b = 32'(hold_b.d);
      et_b = 32'(hold_b.t);
    end
    chk("a.in_ready",  32'(bus_a.in_ready),  32'(m_in_ready));
    chk("a.out_valid", 32'(bus_a.out_valid), 32'(n != 0));
    chk("a.occ",       32'(occ_a),           32'(n));
    chk("a.out_data",  32'(bus_a.out_data),  ed_a);
    chk("a.out_trace", 32'(bus_a.out_trace), 0);
    chk("b.in_ready",  32'(bus_b.in_ready),  32'(m_in_ready));
    chk("b.out_valid", 32'(bus_b.out_valid), 32'(n != 0));
    chk("b.occ",       32'(occ_b),           32'(n));
    chk("b.out_data",  32'(bus_b.out_data),  ed_b);
    chk("b.out_trace", 32'(bus_b.out_trace), et_b);
  endtask

  // One clock: log the DUT's own pop, advance the model, then check at negedge.
  task automatic step();
    bit push, pop;
    if (!ARESET && !flush_en && bus_a.out_valid && out_ready && !stall_en)
      obs_a.push_back(bus_a.out_data);
    @(posedge ACLK);
    push = in_valid && m_in_ready;
    pop  = (q.size() != 0) && out_ready && !stall_en;
    last_push = push && !ARESET && !flush_en;
    if (ARESET || flush_en) begin
      q.delete();
      hold_b = '0;
    end else begin
      if (pop) begin
        hold_b = q[0];
        q.delete(0);
      end
      if (push) q.push_back('{d: in_data, t: in_trace});
    end
    m_in_ready = (q.size() < 2);
    @(negedge ACLK);
    check_all();
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [TW-1:0] t);
    in_valid = v;
    in_data  = d;
    in_trace = t;
  endtask

  initial begin
    int base;
    int hits;

    // Reset held two cycles.
    ARESET = 1'b1;
    step();
    step();
    chk("reset.in_ready", 32'(bus_a.in_ready), 1);
    chk("reset.out_data", 32'(bus_b.out_data), 0);

    // Stream 0x11..0x88 with out_ready high.
    ARESET = 1'b0;
    out_ready = 1'b1;
    base = obs_a.size();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'((i + 1) * 16'h11), 8'(i));
      step();
      chk("stream.occ_le1", 32'(occ_a <= 2'd1), 1);
    end
    drive(1'b0, '0, '0);
    step();
    step();
    chk("stream.count", 32'(obs_a.size() - base), 8);
    if (obs_a.size() - base >= 8)
      for (int i = 0; i < 8; i++)
        chk("stream.order", 32'(obs_a[base + i]), 32'((i + 1) * 16'h11));

    // Fill both entries with out_ready low, then drain.
    out_ready = 1'b0;
    drive(1'b1, 16'hA1, 8'h01); step();
    drive(1'b1, 16'hA2, 8'h02); step();
    chk("fill.occ", 32'(occ_a), 2);
    chk("fill.in_ready", 32'(bus_a.in_ready), 0);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    base = obs_a.size();
    step();
    chk("drain.in_ready", 32'(bus_a.in_ready), 1);
    step();
    step();
    chk("drain.count", 32'(obs_a.size() - base), 2);
    if (obs_a.size() - base >= 2) begin
      chk("drain.first", 32'(obs_a[base]), 32'h A1);
      chk("drain.second", 32'(obs_a[base + 1]), 32'h A2);
    end

    // Stall holds the output; a push during stall still lands in the skid.
    out_ready = 1'b0;
    drive(1'b1, 16'hB0, 8'h10); step();
    drive(1'b0, '0, '0);
    stall_en = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    drive(1'b1, 16'hB1, 8'h11); step();
    drive(1'b0, '0, '0);
    chk("stall.out_data", 32'(bus_a.out_data), 32'hB0);
    chk("stall.occ", 32'(occ_a), 2);
    stall_en = 1'b0;
    base = obs_a.size();
    step();
    step();
    step();
    chk("stall.count", 32'(obs_a.size() - base), 2);
    if (obs_a.size() - base >= 2) begin
      chk("stall.first", 32'(obs_a[base]), 32'hB0);
      chk("stall.second", 32'(obs_a[base + 1]), 32'hB1);
    end

    // Flush from HALF (in_ready=1) and from FULL, each with a push of 0xC3.
    out_ready = 1'b0;
    base = obs_a.size();
    drive(1'b1, 16'hC1, 8'h21); step();
    flush_en = 1'b1;
    drive(1'b1, 16'hC3, 8'h23); step();
    flush_en = 1'b0;
    chk("flush_half.occ", 32'(occ_a), 0);
    chk("flush_half.in_ready", 32'(bus_a.in_ready), 1);
    drive(1'b1, 16'hC1, 8'h21); step();
    drive(1'b1, 16'hC2, 8'h22); step();
    flush_en = 1'b1;
    drive(1'b1, 16'hC3, 8'h23); step();
    flush_en = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_full.occ", 32'(occ_a), 0);
    chk("flush_full.out_valid", 32'(bus_a.out_valid), 0);
    chk("flush_full.out_data", 32'(bus_a.out_data), 0);
    chk("flush_full.in_ready", 32'(bus_a.in_ready), 1);
    out_ready = 1'b1;
    step();
    step();
    hits = 0;
    for (int i = base; i < obs_a.size(); i++)
      if (obs_a[i] == 16'hC3) hits++;
    chk("flush.c3_absent", 32'(hits), 0);

    // Reset in FULL with stall active, held two cycles.
    out_ready = 1'b0;
    drive(1'b1, 16'hD1, 8'h31); step();
    drive(1'b1, 16'hD2, 8'h32); step();
    stall_en = 1'b1;
    ARESET = 1'b1;
    drive(1'b0, '0, '0);
    step();
    chk("rst.occ", 32'(occ_a), 0);
    chk("rst.out_valid", 32'(bus_b.out_valid), 0);
    chk("rst.out_trace", 32'(bus_b.out_trace), 0);
    step();
    chk("rst_hold.in_ready", 32'(bus_a.in_ready), 1);
    ARESET = 1'b0;
    stall_en = 1'b0;
    drive(1'b1, 16'hD4, 8'h34); step();
    drive(1'b0, '0, '0);
    chk("rst.d4_out", 32'(bus_a.out_data), 32'hD4);
    chk("rst.d4_valid", 32'(bus_a.out_valid), 1);

    // Pop to EMPTY: BUBBLE_ZERO=0 holds data and trace, BUBBLE_ZERO=1 clears.
    out_ready = 1'b1;
    step();
    drive(1'b1, 16'hE5, 8'h5A); step();
    drive(1'b0, '0, '0);
    step();
    chk("hold.b_data", 32'(bus_b.out_data), 32'hE5);
    chk("hold.b_trace", 32'(bus_b.out_trace), 32'h5A);
    chk("hold.b_valid", 32'(bus_b.out_valid), 0);
    chk("hold.a_data", 32'(bus_a.out_data), 0);

    // Randomized traffic; a pending beat stays stable until it is pushed.
    for (int c = 0; c < 600; c++) begin
      if (!(in_valid && !last_push))
        drive($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      stall_en  = ($urandom_range(0, 7) == 0);
      flush_en  = ($urandom_range(0, 31) == 0);
      ARESET    = ($urandom_range(0, 127) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
